// File: rtl/gpi_ctrl.sv
// General-purpose input peripheral: synchronised, debounced pins with a data register,
// per-bit rise/fall event enables, a W1C status register and a level interrupt.
module gpi_ctrl #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DB_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs,
  input  logic             wr,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpi,
  output logic             irq
);

  localparam int unsigned        CNT_W    = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_RISE_EN = 2'd1;
  localparam logic [1:0] ADDR_FALL_EN = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [CNT_W-1:0] w_cnt_next [WIDTH];
  logic [WIDTH-1:0] r_filt;
  logic [WIDTH-1:0] r_rise_en;
  logic [WIDTH-1:0] r_fall_en;
  logic [WIDTH-1:0] r_status;

  logic [WIDTH-1:0] w_s;
  logic [WIDTH-1:0] w_filt_next;
  logic [WIDTH-1:0] w_events;
  logic [WIDTH-1:0] w_clr_mask;
  logic             w_wr;

  // Metastability chain per pin
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= gpi;
      for (int i = 1; i < int'(SYNC_STAGES); i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // A new level is accepted only after DB_CYCLES consecutive differing samples
  always_comb begin
    w_filt_next = r_filt;
    w_cnt_next  = r_cnt;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (w_s[i] == r_filt[i]) begin
        w_cnt_next[i] = '0;
      end else if (r_cnt[i] == CNT_LAST) begin
        w_filt_next[i] = w_s[i];
        w_cnt_next[i]  = '0;
      end else begin
        w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
      end
    end
  end

  assign w_events = (~r_filt & w_filt_next & r_rise_en) |
                    (r_filt & ~w_filt_next & r_fall_en);

  assign w_wr       = cs & wr;
  assign w_clr_mask = (w_wr && addr == ADDR_STATUS) ? wdata[WIDTH-1:0] : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_filt <= '0;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= '0;
    end else begin
      r_filt <= w_filt_next;
      for (int i = 0; i < int'(WIDTH); i++) r_cnt[i] <= w_cnt_next[i];
    end
  end

  // Event enables sample the pre-write value, so a same-edge write gates only later events
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
    end else begin
      if (w_wr && addr == ADDR_RISE_EN) r_rise_en <= wdata[WIDTH-1:0];
      if (w_wr && addr == ADDR_FALL_EN) r_fall_en <= wdata[WIDTH-1:0];
      r_status <= (r_status & ~w_clr_mask) | w_events;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      ADDR_DATA:    rdata = 32'(r_filt);
      ADDR_RISE_EN: rdata = 32'(r_rise_en);
      ADDR_FALL_EN: rdata = 32'(r_fall_en);
      ADDR_STATUS:  rdata = 32'(r_status);
      default:      rdata = '0;
    endcase
  end

  assign irq = |r_status;

endmodule
